// File: rtl/stdp_weight_bank_if.sv
// ---------------------------------------------------------------------------
// stdp_weight_bank_if
//
// Request/response bundle for stdp_weight_bank.
//
// Parameters
//   AW       synapse address width (must equal the bank's derived AW)
//   W_WIDTH  weight width
//   STEP_W   update step width
//
// Signals
//   req_valid  request present                     (master -> slave)
//   req_ready  bank accepts a request this cycle   (slave  -> master)
//   req_addr   synapse index                       (master -> slave)
//   req_op     00 read, 01 add, 10 subtract, 11 clear
//   req_step   magnitude for add/subtract          (master -> slave)
//   rsp_valid  one-cycle response pulse            (slave  -> master)
//   rsp_addr   address of the completed request
//   rsp_weight weight after the update
//   rsp_sat    result was clamped
//   rsp_err    address out of range, nothing written
//   we         registered write strobe
// ---------------------------------------------------------------------------
interface stdp_weight_bank_if #(
    parameter int AW      = 2,
    parameter int W_WIDTH = 11,
    parameter int STEP_W  = 4
);
    logic               req_valid;
    logic               req_ready;
    logic [AW-1:0]      req_addr;
    logic [1:0]         req_op;
    logic [STEP_W-1:0]  req_step;
    logic               rsp_valid;
    logic [AW-1:0]      rsp_addr;
    logic [W_WIDTH-1:0] rsp_weight;
    logic               rsp_sat;
    logic               rsp_err;
    logic               we;

    modport master (
        output req_valid, req_addr, req_op, req_step,
        input  req_ready, rsp_valid, rsp_addr, rsp_weight, rsp_sat, rsp_err, we
    );

    modport slave (
        input  req_valid, req_addr, req_op, req_step,
        output req_ready, rsp_valid, rsp_addr, rsp_weight, rsp_sat, rsp_err, we
    );
endinterface

// File: rtl/stdp_weight_bank.sv
// ---------------------------------------------------------------------------
// stdp_weight_bank
//
// Bank of N_SYN unsigned synapse weights with single-cycle saturating
// read-modify-write updates (potentiate / depress / clear / read).
// A request is accepted on a rising edge when req_valid && req_ready; the
// updated weight is stored on that same edge and reported on the bus for
// exactly one cycle afterwards.
//
// Optional feature (compile-time macro STDP_DECAY_EN):
//   a free-running idle counter triggers a decay sweep every DECAY_PERIOD
//   cycles; the sweep walks all addresses in order, one per cycle,
//   decrementing each weight by 1 (floored at 0) while req_ready is low.
//   With the macro undefined there is no counter and no sweep.
//
// Ports
//   clk   clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   stdp_weight_bank_if.slave (request/response bundle, see interface)
//
// The interface instance must be built with AW = max(1, clog2(N_SYN)) and
// the same W_WIDTH / STEP_W as this module.
// ---------------------------------------------------------------------------
module stdp_weight_bank #(
    parameter int N_SYN        = 4,
    parameter int W_WIDTH      = 11,
    parameter int STEP_W       = 4,
    parameter int INIT_W       = 0,
    parameter int DECAY_PERIOD = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    stdp_weight_bank_if.slave     bus
);
    localparam int AW = (N_SYN > 1) ? $clog2(N_SYN) : 1;

    localparam logic [W_WIDTH-1:0] W_MAX  = {W_WIDTH{1'b1}};
    localparam logic [W_WIDTH-1:0] W_INIT = W_WIDTH'(INIT_W);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_POT   = 2'b01;
    localparam logic [1:0] OP_DEP   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t state_reg, state_next;

    // Weight storage and per-entry next values
    logic [W_WIDTH-1:0] weight_reg [N_SYN];
    logic [W_WIDTH-1:0] weight_next [N_SYN];

    // Response / strobe registers
    logic               req_ready_reg;
    logic               rsp_valid_reg;
    logic [AW-1:0]      rsp_addr_reg;
    logic [W_WIDTH-1:0] rsp_weight_reg;
    logic               rsp_sat_reg;
    logic               rsp_err_reg;
    logic               we_reg;

    // Request datapath
    logic               accept;
    logic               addr_ok;
    logic [W_WIDTH-1:0] cur_w;
    logic [W_WIDTH:0]   step_ext;
    logic [W_WIDTH:0]   sum_w;
    logic [W_WIDTH:0]   diff_w;
    logic [W_WIDTH-1:0] new_w;
    logic               new_sat;
    logic               do_write;

    // Sweep control (constant zero when decay is not built in)
    logic               sweep_wr;
    logic [AW-1:0]      sweep_idx;

    assign accept   = bus.req_valid && req_ready_reg;
    assign addr_ok  = (32'(bus.req_addr) < N_SYN);
    assign step_ext = {{(W_WIDTH + 1 - STEP_W){1'b0}}, bus.req_step};
    assign sum_w    = {1'b0, cur_w} + step_ext;
    assign diff_w   = {1'b0, cur_w} - step_ext;

    // Read mux guarded per entry so out-of-range addresses on a
    // non-power-of-two bank never index past the array.
    always_comb begin
        cur_w = '0;
        for (int i = 0; i < N_SYN; i++) begin
            if (bus.req_addr == AW'(i)) begin
                cur_w = weight_reg[i];
            end
        end
    end

    // Saturating update. The extra top bit of sum/diff flags overflow or
    // borrow respectively.
    always_comb begin
        new_w    = cur_w;
        new_sat  = 1'b0;
        do_write = 1'b0;
        case (bus.req_op)
            OP_READ: begin
                new_w = cur_w;
            end
            OP_POT: begin
                do_write = 1'b1;
                if (sum_w[W_WIDTH]) begin
                    new_w   = W_MAX;
                    new_sat = 1'b1;
                end else begin
                    new_w = sum_w[W_WIDTH-1:0];
                end
            end
            OP_DEP: begin
                do_write = 1'b1;
                if (diff_w[W_WIDTH]) begin
                    new_w   = '0;
                    new_sat = 1'b1;
                end else begin
                    new_w = diff_w[W_WIDTH-1:0];
                end
            end
            OP_CLEAR: begin
                do_write = 1'b1;
                new_w    = W_INIT;
            end
            default: begin
                new_w = cur_w;
            end
        endcase
        if (!addr_ok) begin
            new_w    = '0;
            new_sat  = 1'b0;
            do_write = 1'b0;
        end
    end

    // Per-entry write selection. Requests and sweeps never overlap because
    // req_ready is low for the whole sweep.
    generate
        for (genvar gi = 0; gi < N_SYN; gi++) begin : g_entry
            logic req_hit;
            logic sweep_hit;
            assign req_hit   = accept && do_write && (bus.req_addr == AW'(gi));
            assign sweep_hit = sweep_wr && (sweep_idx == AW'(gi));
            assign weight_next[gi] =
                req_hit   ? new_w :
                sweep_hit ? ((weight_reg[gi] == '0) ? '0 : weight_reg[gi] - W_WIDTH'(1)) :
                            weight_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SYN; i++) begin
                weight_reg[i] <= W_INIT;
            end
        end else begin
            for (int i = 0; i < N_SYN; i++) begin
                weight_reg[i] <= weight_next[i];
            end
        end
    end

`ifdef STDP_DECAY_EN
    localparam int CNT_W = (DECAY_PERIOD > 2) ? $clog2(DECAY_PERIOD) : 1;

    logic [CNT_W-1:0] cnt_reg;
    logic [AW-1:0]    sweep_idx_reg;
    logic             sweep_due;
    logic             sweep_last;

    assign sweep_due  = (cnt_reg == CNT_W'(DECAY_PERIOD - 1));
    assign sweep_last = (sweep_idx_reg == AW'(N_SYN - 1));
    assign sweep_idx  = sweep_idx_reg;

    always_comb begin
        state_next = state_reg;
        sweep_wr   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sweep_due) begin
                    state_next = SWEEP;
                end
            end
            SWEEP: begin
                sweep_wr = 1'b1;
                if (sweep_last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Idle counter restarts from zero whenever a sweep is entered or running,
    // so the next sweep is a full period after the previous one ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg       <= '0;
            sweep_idx_reg <= '0;
        end else begin
            if (state_reg == IDLE && !sweep_due) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end else begin
                cnt_reg <= '0;
            end
            if (state_reg == SWEEP && !sweep_last) begin
                sweep_idx_reg <= sweep_idx_reg + AW'(1);
            end else begin
                sweep_idx_reg <= '0;
            end
        end
    end
`else
    assign sweep_idx = '0;

    always_comb begin
        state_next = IDLE;
        sweep_wr   = 1'b0;
        case (state_reg)
            IDLE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // req_ready is a register: it follows the next state, so it rises on the
    // first edge after reset and drops on the edge that enters a sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready_reg  <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_addr_reg   <= '0;
            rsp_weight_reg <= '0;
            rsp_sat_reg    <= 1'b0;
            rsp_err_reg    <= 1'b0;
            we_reg         <= 1'b0;
        end else begin
            req_ready_reg <= (state_next == IDLE);
            rsp_valid_reg <= accept;
            we_reg        <= (accept && do_write) || sweep_wr;
            // Response fields hold their last values between responses.
            if (accept) begin
                rsp_addr_reg   <= bus.req_addr;
                rsp_weight_reg <= new_w;
                rsp_sat_reg    <= new_sat;
                rsp_err_reg    <= !addr_ok;
            end
        end
    end

    assign bus.req_ready  = req_ready_reg;
    assign bus.rsp_valid  = rsp_valid_reg;
    assign bus.rsp_addr   = rsp_addr_reg;
    assign bus.rsp_weight = rsp_weight_reg;
    assign bus.rsp_sat    = rsp_sat_reg;
    assign bus.rsp_err    = rsp_err_reg;
    assign bus.we         = we_reg;

endmodule

// File: tb/tb_stdp_weight_bank.sv
// ---------------------------------------------------------------------------
// tb_stdp_weight_bank
//
// Directed bench for stdp_weight_bank. Default build uses a 3-entry bank so
// an out-of-range address exists; with STDP_DECAY_EN a 4-entry bank with a
// 16-cycle decay period is used for the sweep scenarios.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stdp_weight_bank;
`ifdef STDP_DECAY_EN
    localparam int N_SYN = 4;
`else
    localparam int N_SYN = 3;
`endif
    localparam int W_WIDTH = 11;
    localparam int STEP_W  = 4;
    localparam int AW      = (N_SYN > 1) ? $clog2(N_SYN) : 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    stdp_weight_bank_if #(.AW(AW), .W_WIDTH(W_WIDTH), .STEP_W(STEP_W)) bus ();

    stdp_weight_bank #(
        .N_SYN(N_SYN), .W_WIDTH(W_WIDTH), .STEP_W(STEP_W),
        .INIT_W(0), .DECAY_PERIOD(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives one request (called just after a rising edge), lets it be
    // accepted on the next edge and checks the response one cycle later.
    // Consecutive calls are back-to-back.
    task automatic issue(input int a, input int op, input int st,
                         input int ew, input int esat, input int eerr, input int ewe,
                         input string tag);
        bus.req_valid = 1'b1;
        bus.req_addr  = AW'(a);
        bus.req_op    = 2'(op);
        bus.req_step  = STEP_W'(st);
        check({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        check({tag, ".valid"},  32'(bus.rsp_valid),  32'd1);
        check({tag, ".addr"},   32'(bus.rsp_addr),   32'(a));
        check({tag, ".weight"}, 32'(bus.rsp_weight), 32'(ew));
        check({tag, ".sat"},    32'(bus.rsp_sat),    32'(esat));
        check({tag, ".err"},    32'(bus.rsp_err),    32'(eerr));
        check({tag, ".we"},     32'(bus.we),         32'(ewe));
        bus.req_valid = 1'b0;
    endtask

    initial begin
        int exp_w;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_op    = 2'b00;
        bus.req_step  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.ready",  32'(bus.req_ready),  32'd0);
        check("rst.valid",  32'(bus.rsp_valid),  32'd0);
        check("rst.weight", 32'(bus.rsp_weight), 32'd0);
        check("rst.we",     32'(bus.we),         32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel.ready_before_edge", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        check("rel.ready_after_edge", 32'(bus.req_ready), 32'd1);

`ifndef STDP_DECAY_EN
        // Five unit potentiations on addr 0
        for (int k = 1; k <= 5; k++) begin
            issue(0, 1, 1, k, 0, 0, 1, "pot_a0");
        end
        // Idle cycle: no pulse, fields hold
        @(posedge clk);
        #1;
        check("hold.valid",  32'(bus.rsp_valid),  32'd0);
        check("hold.weight", 32'(bus.rsp_weight), 32'd5);
        check("hold.addr",   32'(bus.rsp_addr),   32'd0);
        // Zero step: unchanged, written, no saturation
        issue(0, 1, 0, 5, 0, 0, 1, "pot_step0");
        issue(0, 2, 0, 5, 0, 0, 1, "dep_step0");

        // Saturation up and down on addr 1
        issue(1, 3, 0, 0, 0, 0, 1, "clr_a1");
        for (int k = 1; k <= 137; k++) begin
            exp_w = (15 * k > 2047) ? 2047 : 15 * k;
            issue(1, 1, 15, exp_w, (k == 137) ? 1 : 0, 0, 1, "sat_up");
        end
        for (int k = 1; k <= 137; k++) begin
            exp_w = (2047 - 15 * k < 0) ? 0 : 2047 - 15 * k;
            issue(1, 2, 15, exp_w, (k == 137) ? 1 : 0, 0, 1, "sat_dn");
        end
        issue(1, 1, 9, 9, 0, 0, 1, "pot_a1");

        // Alternating back-to-back on addr 2
        issue(2, 1, 2, 2, 0, 0, 1, "alt1");
        issue(2, 2, 2, 0, 0, 0, 1, "alt2");
        issue(2, 1, 2, 2, 0, 0, 1, "alt3");
        issue(2, 2, 2, 0, 0, 0, 1, "alt4");

        // Out-of-range address
        issue(3, 1, 5, 0, 0, 1, 0, "oor_pot");
        issue(3, 2, 1, 0, 0, 1, 0, "oor_dep");
        issue(3, 3, 0, 0, 0, 1, 0, "oor_clr");
        issue(0, 0, 0, 5, 0, 0, 0, "rd_a0");
        issue(1, 0, 0, 9, 0, 0, 0, "rd_a1");
        issue(2, 0, 0, 0, 0, 0, 0, "rd_a2");

        // Clear then read back
        issue(0, 3, 0, 0, 0, 0, 1, "clr_a0");
        issue(0, 0, 0, 0, 0, 0, 0, "rd_a0_clr");

        // Reset in the response cycle
        issue(2, 1, 7, 7, 0, 0, 1, "pre_rst");
        rst = 1'b1;
        #1;
        check("mid_rst.valid",  32'(bus.rsp_valid),  32'd0);
        check("mid_rst.weight", 32'(bus.rsp_weight), 32'd0);
        check("mid_rst.we",     32'(bus.we),         32'd0);
        check("mid_rst.ready",  32'(bus.req_ready),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rel2.ready", 32'(bus.req_ready), 32'd1);
        issue(2, 0, 0, 0, 0, 0, 0, "rd_a2_rst");
        issue(1, 0, 0, 0, 0, 0, 0, "rd_a1_rst");
`else
        begin
            int low_cnt;
            issue(0, 1, 3, 3, 0, 0, 1, "set_a0");
            issue(2, 1, 5, 5, 0, 0, 1, "set_a2");
            issue(3, 1, 1, 1, 0, 0, 1, "set_a3");

            // Wait for the sweep to start
            for (int i = 0; i < 40 && bus.req_ready; i++) begin
                @(posedge clk);
                #1;
            end
            check("sweep_start.ready", 32'(bus.req_ready), 32'd0);

            // Request held across the sweep
            bus.req_valid = 1'b1;
            bus.req_addr  = AW'(0);
            bus.req_op    = 2'b00;
            bus.req_step  = '0;
            low_cnt = 1;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                #1;
                check("sweep.no_rsp", 32'(bus.rsp_valid), 32'd0);
                if (bus.req_ready) break;
                low_cnt++;
            end
            check("sweep.low_cycles", 32'(low_cnt), 32'd4);
            @(posedge clk);
            #1;
            check("held.valid",  32'(bus.rsp_valid),  32'd1);
            check("held.weight", 32'(bus.rsp_weight), 32'd2);
            check("held.we",     32'(bus.we),         32'd0);
            bus.req_valid = 1'b0;
            issue(1, 0, 0, 0, 0, 0, 0, "decay_a1");
            issue(2, 0, 0, 4, 0, 0, 0, "decay_a2");
            issue(3, 0, 0, 0, 0, 0, 0, "decay_a3");

            // Reset in the middle of the next sweep
            for (int i = 0; i < 40 && bus.req_ready; i++) begin
                @(posedge clk);
                #1;
            end
            check("sweep2_start.ready", 32'(bus.req_ready), 32'd0);
            @(posedge clk);
            #1;
            rst = 1'b1;
            #1;
            check("sw_rst.ready", 32'(bus.req_ready), 32'd0);
            check("sw_rst.valid", 32'(bus.rsp_valid), 32'd0);
            check("sw_rst.we",    32'(bus.we),        32'd0);
            @(negedge clk);
            rst = 1'b0;
            #1;
            check("sw_rel.ready_before_edge", 32'(bus.req_ready), 32'd0);
            @(posedge clk);
            #1;
            check("sw_rel.ready_after_edge", 32'(bus.req_ready), 32'd1);
            for (int a = 0; a < 4; a++) begin
                issue(a, 0, 0, 0, 0, 0, 0, "rd_after_sw_rst");
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/stdp_weight_bank.md
STDP_WEIGHT_BANK -- requirements
Module: stdp_weight_bank

Interface
REQ-001 SHALL have parameter N_SYN, default 4: number of synapse weights stored.
REQ-002 SHALL have parameter W_WIDTH, default 11: weight width, unsigned.
REQ-003 SHALL have parameter STEP_W, default 4: width of the update step.
REQ-004 SHALL have parameter INIT_W, default 0: weight value loaded on reset.
REQ-005 SHALL have parameter DECAY_PERIOD, default 1024: clk cycles between decay sweeps; used only with STDP_DECAY_EN.
REQ-006 SHALL derive AW = max(1, clog2(N_SYN)) as address width.
REQ-007 clk  in  1  clock, rising edge.
REQ-008 rst  in  1  reset: rst, asynchronous, active-high; clock clk.
REQ-009 req_valid  in  1  update request present.
REQ-010 req_ready  out  1  block accepts a request this cycle.
REQ-011 req_addr  in  AW  synapse index.
REQ-012 req_op  in  2  00 read, 01 potentiate (add), 10 depress (subtract), 11 clear to INIT_W.
REQ-013 req_step  in  STEP_W  magnitude for ops 01/10.
REQ-014 rsp_valid  out  1  one-cycle pulse, response fields valid.
REQ-015 rsp_addr  out  AW  address of the completed request.
REQ-016 rsp_weight  out  W_WIDTH  weight after the update.
REQ-017 rsp_sat  out  1  result clamped to the range limit.
REQ-018 rsp_err  out  1  req_addr >= N_SYN; no update made.
REQ-019 we  out  1  registered write strobe, high the cycle after any memory write, request or sweep.

Function
REQ-020 Accept SHALL occur on a rising edge with req_valid && req_ready; the read-modify-write SHALL complete on that edge.
REQ-021 rsp_valid SHALL be high exactly the cycle after accept, with rsp_addr/rsp_weight/rsp_sat/rsp_err from that request; latency 1, throughput 1 request/cycle.
REQ-022 Back-to-back requests to one address SHALL see the previous result, with no stale read.
REQ-023 Op 01 SHALL compute w+step in W_WIDTH+1 bits; result > 2^W_WIDTH-1 -> store 2^W_WIDTH-1, rsp_sat=1.
REQ-024 Op 10 SHALL compute w-step; underflow -> store 0, rsp_sat=1.
REQ-025 step=0 on op 01/10 SHALL leave w unchanged, rsp_sat=0, we=1.
REQ-026 Ops 00 and 11 SHALL give rsp_sat=0; op 00 SHALL not write, so we=0.
REQ-027 Out-of-range address SHALL give rsp_err=1, rsp_weight=0, no write, we=0.
REQ-028 rsp_weight/rsp_sat/rsp_err SHALL hold their last values when rsp_valid=0.
REQ-029 FSM states: IDLE (req_ready=1) and SWEEP (req_ready=0); req_ready SHALL be registered.

Reset
REQ-030 While rst is high: all weights=INIT_W, FSM=IDLE, req_ready=0, rsp_valid=0, rsp_weight=0, rsp_addr=0, rsp_sat=0, rsp_err=0, we=0, decay counter=0.
REQ-031 req_ready SHALL rise on the first clk edge after rst falls.
REQ-032 Reset during a SWEEP or in the response cycle SHALL abort it; nothing partial SHALL survive.

Configuration
REQ-033 Macro STDP_DECAY_EN defined: a free-running counter SHALL count clk cycles in IDLE.
REQ-034 At DECAY_PERIOD-1 the FSM SHALL enter SWEEP with req_ready=0.
REQ-035 SWEEP SHALL take N_SYN cycles; each cycle decrements one weight by 1, in address order, saturating at 0.
REQ-036 On sweep end the FSM SHALL return to IDLE and the counter SHALL restart.
REQ-037 A request pending at sweep start SHALL wait, not be lost.
REQ-038 Macro STDP_DECAY_EN undefined: no counter and no SWEEP; req_ready=1 at all times after reset.

Verification
REQ-039 Reset, then op 01 step 1 at addr 0, five times -> rsp_weight 1,2,3,4,5, each one cycle after accept.
REQ-040 W_WIDTH=11, addr 1 cleared then op 01 step 15 x137 -> 2047 with rsp_sat=1 on the last; then op 10 step 15 x137 -> reaches 0, rsp_sat=1 on the last.
REQ-041 N_SYN=3, addr 3 -> rsp_err=1, rsp_weight=0, we=0, other weights unchanged.
REQ-042 Alternating op 01/10 step 2 on addr 2, back-to-back -> weights 2,0,2,0, no stale value.
REQ-043 STDP_DECAY_EN, DECAY_PERIOD=16, weights {3,0,5,1} -> req_ready low 4 cycles, then weights {2,0,4,0}; request held during sweep completes after.
REQ-044 rst asserted mid-sweep -> all weights INIT_W, rsp_valid=0, req_ready=0 until the first edge after release.
